alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, handshaked successor to the single-cycle combinational ALU. It keeps the existing five-opcode encoding and semantics, and adds XOR, signed compare, shifts, iterative unsigned multiply (low/high), and iterative unsigned divide/remainder. It sits between issue and writeback in the execute stage. Operands enter through a valid/ready input channel; results leave through a valid/ready output channel with a registered result.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a power of two, at least 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived, not overridden.
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: operands and op present.
- `in_ready` out 1: block can accept an operation this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `op` in 4: operation code (see Operation).
- `out_valid` out 1: `y` holds a completed result.
- `out_ready` in 1: consumer takes `y` this cycle.
- `y` out WIDTH: registered result.
- `busy` out 1: high while an iterative op is in progress.

## Operation
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND.
  - 3 OR.
  - 4 SLT: unsigned a<b, zero-extended to WIDTH. Identical to the legacy encoding.
  - 5 XOR.
  - 6 SLTS: signed a<b, zero-extended.
  - 7 SLL: a << b[SHW-1:0].
  - 8 SRL: logical right shift by b[SHW-1:0].
  - 9 SRA: arithmetic right shift by b[SHW-1:0].
  - 10 MUL: low WIDTH bits of a*b, unsigned.
  - 11 MULHU: high WIDTH bits of the 2·WIDTH unsigned product.
  - 12 DIVU: a/b, unsigned.
  - 13 REMU: a%b, unsigned.
  - 14, 15: reserved. Result is 0 with single-cycle latency.
- Upper bits of `b` above SHW are ignored for shifts.
- Divide by zero:
  - DIVU returns all-ones.
  - REMU returns `a`.
  - Still takes the full iterative latency. No flag.
- MUL/MULHU use a shift-add datapath: one partial product per cycle, 2·WIDTH accumulator.
- DIVU/REMU use restoring division: one quotient bit per cycle, WIDTH+1-bit partial remainder.
- Operands are captured at accept time. `a`, `b` and `op` may change freely afterwards.
- State machine:
  - IDLE: `in_ready`=1. On accept of a single-cycle op, compute, register `y`, go to DONE. On accept of an iterative op (10–13), load operands, clear counter, go to BUSY.
  - BUSY: `in_ready`=0, `busy`=1. Counter increments each cycle. After WIDTH iterations, register `y` and go to DONE.
  - DONE: `out_valid`=1, `y` stable. If `out_ready`=0, hold. If `out_ready`=1 and no new accept, go to IDLE. If `out_ready`=1 and `in_valid`=1, accept the new op in the same cycle, using the same transitions as IDLE.
- `in_ready` = (state==IDLE) or (state==DONE and `out_ready`). Combinational from state and `out_ready` only. Never from `in_valid`.
- Accept occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.

## Timing
- Reset values, effective at the first rising edge with `rst`=1:
  - state IDLE
  - `out_valid`=0
  - `busy`=0
  - `y`=0
  - counter 0
  - `in_ready`=1 once reset deasserts
- `rst` overrides everything, including mid-BUSY. The in-flight op is dropped with no output produced.
- Single-cycle op accepted at edge N: `out_valid`=1 and `y` valid from edge N+1.
- Iterative op accepted at edge N:
  - `busy`=1 from edge N+1 through edge N+WIDTH.
  - `out_valid`=1 from edge N+WIDTH+1.
  - Latency is WIDTH+1 cycles, independent of operand values.
- Back-to-back single-cycle ops with `out_ready` held high give one result per cycle.
- `y` and `out_valid` are driven from registers. There is no combinational path from inputs to `y`.
- While `out_valid`=1 and `out_ready`=0, `y` must not change for any number of cycles.

## Test plan
- Reset, then ADD a=0xFFFF_FFFF, b=1 (WIDTH=32) -> `y`=0 one cycle after accept. Then SLT a=1, b=0xFFFF_FFFF -> `y`=1. Then SLTS with the same operands -> `y`=0.
- SRA a=0x8000_0000, b=0x0000_0024 -> shift amount 4, `y`=0xF800_0000. SRL with the same operands -> `y`=0x0800_0000.
- MUL/MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF:
  - `busy` high for exactly 32 cycles.
  - `out_valid` at accept+33.
  - MUL `y`=0x0000_0001; MULHU `y`=0xFFFF_FFFE.
- DIVU a=100, b=7 -> `y`=14; REMU -> `y`=2. DIVU a=5, b=0 -> 0xFFFF_FFFF; REMU a=5, b=0 -> 5. All with 33-cycle latency.
- Backpressure: hold `out_ready`=0 for 10 cycles after an XOR result -> `y` stable and `in_ready`=0. Then raise `out_ready` with `in_valid` high -> transfer and new accept in the same cycle, next result the following cycle.
- Assert `rst` for one cycle midway through a DIVU -> `out_valid`=0, `busy`=0, `y`=0 next cycle. A following ADD 2+3 returns 5 with normal latency.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle, valid/ready handshaked execute-stage ALU.
// Single-cycle ops produce a registered result one cycle after accept.
// Multiply (shift-add) and divide (restoring) need WIDTH+1 cycles from
// accept to result, and that latency does not depend on the operands.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SLTS  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Result of every op that completes in one cycle; reserved codes give 0.
  function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       fop,
                                                 input logic [WIDTH-1:0] fa,
                                                 input logic [WIDTH-1:0] fb);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    sa = $signed(fa);
    sb = $signed(fb);
    sh = fb[SHW-1:0];
    case (fop)
      OP_ADD:  single_op = fa + fb;
      OP_SUB:  single_op = fa - fb;
      OP_AND:  single_op = fa & fb;
      OP_OR:   single_op = fa | fb;
      OP_SLT:  single_op = {{(WIDTH-1){1'b0}}, (fa < fb)};
      OP_XOR:  single_op = fa ^ fb;
      OP_SLTS: single_op = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLL:  single_op = fa << sh;
      OP_SRL:  single_op = fa >> sh;
      OP_SRA:  single_op = $unsigned(sa >>> sh);
      default: single_op = '0;
    endcase
  endfunction

  function automatic logic is_iterative(input logic [3:0] fop);
    is_iterative = (fop == OP_MUL) || (fop == OP_MULHU) ||
                   (fop == OP_DIVU) || (fop == OP_REMU);
  endfunction

  function automatic logic is_mult(input logic [3:0] fop);
    is_mult = (fop == OP_MUL) || (fop == OP_MULHU);
  endfunction

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [3:0]         op_q, op_d;
  // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
  logic [WIDTH-1:0]   opr_q, opr_d;
  // Shift-add accumulator: high half gathers sums, low half holds the
  // not-yet-consumed multiplier bits.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Restoring divider: remainder and dividend/quotient shift register.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;

  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  // One iteration step of the multiplier and of the divider.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    trial    = {rem_q, quo_q[WIDTH-1]};
    rem_next = trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], 1'b0};
    // A zero divisor always "fits", which naturally yields all-ones
    // quotient and the dividend as remainder.
    if (trial >= {1'b0, opr_q}) begin
      rem_next = WIDTH'(trial - {1'b0, opr_q});
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state, handshake and datapath load/update control.
  always_comb begin
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    accept   = in_valid && in_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    op_d     = op_q;
    opr_d    = opr_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q + SHW'(1);
        if (is_mult(op_q)) begin
          acc_d = mul_next;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          case (op_q)
            OP_MUL:   y_d = mul_next[WIDTH-1:0];
            OP_MULHU: y_d = mul_next[2*WIDTH-1:WIDTH];
            OP_DIVU:  y_d = quo_next;
            default:  y_d = rem_next;
          endcase
        end
      end
      default: begin
        if (accept) begin
          if (is_iterative(op)) begin
            state_d = S_BUSY;
            op_d    = op;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, b};
            opr_d   = is_mult(op) ? a : b;
            rem_d   = '0;
            quo_d   = a;
          end else begin
            state_d = S_DONE;
            y_d     = single_op(op, a, b);
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign y         = y_q;

  // Control state and the visible result register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  // Iterative datapath registers; only meaningful while BUSY.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    opr_q <= opr_d;
    acc_q <= acc_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checking of alu_mc against a
// transaction-level reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result computed with wide plain arithmetic.
  function automatic logic [W-1:0] ref_op(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] z);
    logic [2*W-1:0] p;
    logic [2*W-1:0] ext;
    int             sh;
    sh  = int'(z[4:0]);
    p   = {{W{1'b0}}, x} * {{W{1'b0}}, z};
    ext = {{W{x[W-1]}}, x} >> sh;
    case (o)
      4'd0:    return x + z;
      4'd1:    return x - z;
      4'd2:    return x & z;
      4'd3:    return x | z;
      4'd4:    return (x < z) ? 32'd1 : 32'd0;
      4'd5:    return x ^ z;
      4'd6:    return ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      4'd7:    return x << sh;
      4'd8:    return x >> sh;
      4'd9:    return ext[W-1:0];
      4'd10:   return p[W-1:0];
      4'd11:   return p[2*W-1:W];
      4'd12:   return (z == 0) ? '1 : x / z;
      4'd13:   return (z == 0) ? x : x % z;
      default: return '0;
    endcase
  endfunction

  // Transaction model: remaining busy cycles, pending result, last result.
  int           m_left = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_y = '0;
  logic [W-1:0] m_res = '0;
  bit           m_last_acc = 1'b0;
  bit           chk_en = 1'b0;

  // Reference model advanced on every rising edge.
  always @(posedge clk) begin
    bit rdy;
    bit acc;
    if (rst) begin
      m_left     = 0;
      m_valid    = 1'b0;
      m_y        = '0;
      m_last_acc = 1'b0;
      chk_en     = 1'b1;
    end else begin
      rdy        = (m_left == 0) && (!m_valid || out_ready);
      acc        = in_valid && rdy;
      m_last_acc = acc;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_y     = m_res;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        if (op >= 4'd10 && op <= 4'd13) begin
          m_res   = ref_op(op, a, b);
          m_left  = W;
          m_valid = 1'b0;
        end else begin
          m_y     = ref_op(op, a, b);
          m_valid = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  W'(in_ready),  W'((m_left == 0) && (!m_valid || out_ready)));
      chk("out_valid", W'(out_valid), W'(m_valid));
      chk("busy",      W'(busy),      W'(m_left > 0));
      chk("y",         y,             m_y);
    end
  end

  // Present one op and hold it until accepted, then scramble the inputs.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                       input string nm);
    bit got;
    got = 1'b0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = z;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (m_last_acc) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({nm, " accept"}, W'(got), W'(1));
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  // Wait for the result, checking latency, busy cycles and value.
  task automatic wait_result(input logic [W-1:0] ey, input int elat, input int ebusy,
                             input string nm);
    int lat;
    int bz;
    bit seen;
    lat = 0;
    bz = 0;
    seen = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) bz++;
      if (out_valid) begin
        seen = 1'b1;
        lat = k;
        break;
      end
    end
    chk({nm, " seen"}, W'(seen), W'(1));
    chk({nm, " lat"}, W'(lat), W'(elat));
    chk({nm, " busycyc"}, W'(bz), W'(ebusy));
    chk({nm, " y"}, y, ey);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 7)
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return $urandom % 64;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst y", y, '0);
    chk("rst out_valid", W'(out_valid), '0);
    chk("rst busy", W'(busy), '0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", W'(in_ready), W'(1));

    issue(4'd0, 32'hFFFF_FFFF, 32'd1, "add");
    wait_result(32'h0, 1, 0, "add");
    issue(4'd4, 32'd1, 32'hFFFF_FFFF, "slt");
    wait_result(32'd1, 1, 0, "slt");
    issue(4'd6, 32'd1, 32'hFFFF_FFFF, "slts");
    wait_result(32'd0, 1, 0, "slts");
    issue(4'd9, 32'h8000_0000, 32'h24, "sra");
    wait_result(32'hF800_0000, 1, 0, "sra");
    issue(4'd8, 32'h8000_0000, 32'h24, "srl");
    wait_result(32'h0800_0000, 1, 0, "srl");
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul");
    wait_result(32'h0000_0001, 33, 32, "mul");
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    wait_result(32'hFFFF_FFFE, 33, 32, "mulhu");
    issue(4'd12, 32'd100, 32'd7, "divu");
    wait_result(32'd14, 33, 32, "divu");
    issue(4'd13, 32'd100, 32'd7, "remu");
    wait_result(32'd2, 33, 32, "remu");
    issue(4'd12, 32'd5, 32'd0, "divu0");
    wait_result(32'hFFFF_FFFF, 33, 32, "divu0");
    issue(4'd13, 32'd5, 32'd0, "remu0");
    wait_result(32'd5, 33, 32, "remu0");
    issue(4'd14, 32'h1234, 32'h5678, "rsvd");
    wait_result(32'd0, 1, 0, "rsvd");

    // Backpressure: result must hold while the consumer stalls.
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    issue(4'd5, 32'hA5A5_A5A5, 32'h0F0F_0F0F, "xor");
    wait_result(32'hAAAA_AAAA, 1, 0, "xor");
    repeat (10) begin
      @(negedge clk);
      chk("bp y", y, 32'hAAAA_AAAA);
      chk("bp in_ready", W'(in_ready), '0);
      chk("bp out_valid", W'(out_valid), W'(1));
    end
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 4'd0;
    a = 32'd2;
    b = 32'd3;
    #1;
    chk("bp ready comb", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(32'd5, 1, 0, "bp next");

    // Reset in the middle of a divide.
    issue(4'd12, 32'd100, 32'd7, "divrst");
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", W'(out_valid), '0);
    chk("midrst busy", W'(busy), '0);
    chk("midrst y", y, '0);
    issue(4'd0, 32'd2, 32'd3, "add after rst");
    wait_result(32'd5, 1, 0, "add after rst");

    // Randomized traffic with random backpressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      rst       = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 4'($urandom_range(0, 15));
      a         = pick();
      b         = pick();
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
